cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 122 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, issues the eight word reads of the
// 16-byte block and writes each returned word, then the tag, into the cache arrays.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic        mem_read_en,
  output logic [15:0] memory_address,
  output logic [2:0]  fill_word,
  output logic        fsm_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam logic [3:0] WORDS_PER_BLOCK = 4'd8;
  localparam logic [3:0] LAST_WORD       = 4'd7;

  state_e      state_q, state_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [3:0]  recv_cnt_q, recv_cnt_d;
  logic [15:0] base_q, base_d;

  logic [15:0] miss_base;
  logic        issuing;
  logic        last_word;

  assign miss_base = {miss_address[15:4], 4'h0};
  assign issuing   = (issue_cnt_q < WORDS_PER_BLOCK);
  assign last_word = (recv_cnt_q == LAST_WORD);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
      base_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  // Next-state logic; issue and receive counters advance independently
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    base_d      = base_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          base_d      = miss_base;
          issue_cnt_d = 4'd1;
          recv_cnt_d  = 4'd0;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (issuing) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (memory_data_valid) begin
          recv_cnt_d = recv_cnt_q + 4'd1;
          if (last_word) begin
            recv_cnt_d  = 4'd0;
            issue_cnt_d = 4'd0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; held at zero while reset is asserted, even with a miss pending
  always_comb begin
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = 16'h0000;
    fill_word        = 3'd0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (miss_detected) begin
            fsm_busy       = 1'b1;
            mem_read_en    = 1'b1;
            memory_address = miss_base;
          end
        end
        ST_FILL: begin
          fsm_busy = 1'b1;
          if (issuing) begin
            mem_read_en    = 1'b1;
            memory_address = base_q + {11'd0, issue_cnt_q, 1'b0};
          end
          if (memory_data_valid) begin
            write_data_array = 1'b1;
            fill_word        = recv_cnt_q[2:0];
            write_tag_array  = last_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency memory model.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic [2:0]  fill_word;
  logic        fsm_state_o;

  int checks   = 0;
  int failures = 0;
  int lat      = 4;
  int tag_cnt  = 0;
  logic       spur = 1'b0;
  logic [7:0] pipe = '0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .fill_word         (fill_word),
    .fsm_state_o       (fsm_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: each issued read returns lat cycles later, in order
  always @(posedge clk) pipe <= {pipe[6:0], mem_read_en};
  assign memory_data_valid = spur | pipe[3'(lat - 1)];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic e_busy, input logic e_wd,
                               input logic e_wt, input logic e_rd, input logic [15:0] e_addr,
                               input logic [2:0] e_fw, input logic e_state);
    chk({name, ".busy"},  16'(fsm_busy),         16'(e_busy));
    chk({name, ".wdata"}, 16'(write_data_array), 16'(e_wd));
    chk({name, ".wtag"},  16'(write_tag_array),  16'(e_wt));
    chk({name, ".rd"},    16'(mem_read_en),      16'(e_rd));
    chk({name, ".addr"},  memory_address,        e_addr);
    chk({name, ".state"}, 16'(fsm_state_o),      16'(e_state));
    if (e_wd) chk({name, ".fw"}, 16'(fill_word), 16'(e_fw));
    if (write_tag_array) tag_cnt++;
  endtask

  task automatic check_idle(input string name);
    check_outputs(name, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
  endtask

  // Expected outputs c cycles into a fill started from block base
  task automatic expect_fill(input string name, input int c, input logic [15:0] base);
    logic        e_rd, e_wd, e_wt;
    logic [15:0] e_addr;
    e_rd   = (c < 8);
    e_addr = (c < 8) ? base + 16'(2 * c) : 16'h0000;
    e_wd   = (c >= lat) && (c < lat + 8);
    e_wt   = (c == lat + 7);
    check_outputs($sformatf("%s[%0d]", name, c), 1'b1, e_wd, e_wt, e_rd, e_addr,
                  3'(c - lat), (c != 0));
  endtask

  // Driver: one complete fill, inputs set just after the falling edge
  task automatic run_fill(input string name, input logic [15:0] addr,
                          input logic [15:0] base, input bit change_addr);
    for (int c = 0; c < lat + 8; c++) begin
      miss_detected = (c == 0) || (change_addr && c < lat + 7);
      miss_address  = (change_addr && c >= 3) ? 16'hABCD : addr;
      #1;
      expect_fill(name, c, base);
      @(negedge clk);
    end
    miss_detected = 1'b0;
    #1;
    check_idle({name, ".end"});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle("idle");
    @(negedge clk);

    // Basic fill
    run_fill("basic", 16'h1236, 16'h1230, 1'b0);

    // Address change and miss held during fill
    run_fill("addr_chg", 16'h1236, 16'h1230, 1'b1);

    // Spurious valids in IDLE
    spur = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_idle($sformatf("spur[%0d]", c));
      @(negedge clk);
    end
    spur = 1'b0;

    // Back-to-back fills
    tag_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      miss_detected = (c <= 12);
      miss_address  = (c < 5) ? 16'h0010 : 16'h0020;
      #1;
      if (c < 12)      expect_fill("b2b_a", c, 16'h0010);
      else if (c < 24) expect_fill("b2b_b", c - 12, 16'h0020);
      else             check_idle("b2b_end");
      @(negedge clk);
    end
    chk("b2b_tag_pulses", 16'(tag_cnt), 16'd2);

    // Reset mid-fill after three words received
    for (int c = 0; c < 7; c++) begin
      miss_detected = (c == 0);
      miss_address  = 16'h7A5C;
      #1;
      expect_fill("pre_rst", c, 16'h7A50);
      @(negedge clk);
    end
    rst = 1'b0;
    miss_detected = 1'b1;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    #1;
    check_idle("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    miss_detected = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_idle($sformatf("post_rst_trail[%0d]", c));
      @(negedge clk);
    end
    run_fill("post_rst", 16'h7A5C, 16'h7A50, 1'b0);

    // Latency-1 memory: busy for 9 cycles
    lat = 1;
    run_fill("lat1", 16'h4FFE, 16'h4FF0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
